ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//   Instruction-fetch controller between the program counter and the combinational
//   instruction ROM (word-indexed by addr[31:2], same-cycle ins).
//   Drives the ROM address sequentially and buffers fetched words in a prefetch FIFO.
//   Presents {pc, ins} to decode with a valid/ready handshake.
//   Handles taken branch/jump redirects by flushing and refetching from the new target.
// PARAMETERS
//   DEPTH     4         prefetch FIFO entries; power of 2, >=2
//   RESET_PC  32'h0     first fetch address after reset
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous, active-low reset
//   rom_addr     out  32  address to ROM; bits [1:0] always 0
//   rom_ins      in   32  ROM data for rom_addr, valid in the same cycle
//   halt         in   1   1 = stop issuing new fetches; FIFO still drains
//   redirect     in   1   1-cycle pulse: flush, restart at redirect_pc
//   redirect_pc  in   32  redirect target
//   ins_valid    out  1   FIFO head is valid
//   ins_ready    in   1   decode accepts head this cycle
//   ins_out      out  32  instruction at FIFO head
//   ins_pc       out  32  address of ins_out
//   fetch_busy   out  1   state==FETCH (debug/perf)
// BEHAVIOUR
//   Reset: pc=RESET_PC, FIFO empty, state=IDLE; ins_valid=0, ins_out=0, ins_pc=0,
//     rom_addr=RESET_PC, fetch_busy=0. Reset mid-operation discards all entries.
//   rom_addr = pc combinationally at all times.
//   push = (state==FETCH) & ~redirect & (count<DEPTH | pop); writes {pc, rom_ins}; pc+=4.
//   pop  = ins_valid & ins_ready & ~redirect.
//   Same-cycle push+pop: allowed including when full; count is unchanged.
//   redirect has top priority: FIFO cleared (count=0), pc<=redirect_pc & ~3,
//     no push/pop that cycle; next state FETCH unless halt=1 (then HALTED).
//   pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0, with no special action.
//   ins_valid = (count!=0); ins_out/ins_pc are the head entry, registered and stable
//     while ins_valid & ~ins_ready (no change without pop or redirect).
//   FSM (2 bits):
//     IDLE   -> FETCH (halt=0) | HALTED (halt=1); exited on the first clk after reset.
//     FETCH  -> HALTED if halt; FULL if count will equal DEPTH after this edge;
//               else stays in FETCH.
//     FULL   -> no push; -> FETCH when pop occurs (push resumes next cycle);
//               -> HALTED if halt.
//     HALTED -> no push; -> FETCH when halt=0 and count<DEPTH, else FULL.
//   Latencies: reset release -> ins_valid after 2 edges (IDLE, then first push).
//     redirect at edge N -> target pushed at edge N+1 -> ins_valid visible after N+1.
//   Throughput: 1 instruction/cycle sustained when ins_ready=1.
//   rom_ins X (unmapped address) is stored unchanged; decode owns illegal-instruction handling.
// CONFIGURATION
//   IFETCH_ALIGN_CHK_EN defined: extra port misalign_err (out, 1, reset 0).
//     Set on a redirect with redirect_pc[1:0]!=0; sticky until the next aligned redirect.
//     Target is still truncated to ~3.
//   Not defined: port is absent; redirect_pc[1:0] is silently ignored.
// TESTING
//   1 Reset release, ins_ready=1, ROM words W0..W3 -> ins_pc 0,4,8,C on consecutive
//     cycles, ins_valid first high 2 edges after reset release.
//   2 ins_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 pushes, state FULL, rom_addr=0x10,
//     head held at pc 0; ready=1 -> pcs 0,4,8,C,10 in order, no gap after drain.
//   3 Redirect to 0x40 while FIFO holds 3 entries and ready=1 -> no pop that cycle;
//     next valid ins_pc=0x40; old entries never presented.
//   4 halt=1 with FIFO full, ready=1 -> drains 4 entries, ins_valid=0, rom_addr frozen;
//     halt=0 -> fetch resumes at frozen pc.
//   5 Redirect to 0xFFFF_FFF8 -> ins_pc ...F8, ...FC, then 0x0 (wrap).
//   6 [IFETCH_ALIGN_CHK_EN] redirect_pc=0x22 -> misalign_err=1, ins_pc=0x20;
//     redirect to 0x30 -> misalign_err=0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller.
// Walks the PC through a combinational instruction ROM and buffers {pc, ins}
// pairs in a small prefetch FIFO. Decode takes them through a valid/ready
// handshake. A taken branch or jump (redirect) flushes the FIFO and restarts
// fetching at the new target.
// Optional feature: define IFETCH_ALIGN_CHK_EN to add the misalign_err port.
// That flag is sticky and is set by a redirect whose target has nonzero low bits.
module ifetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_ins,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
`ifdef IFETCH_ALIGN_CHK_EN
  output logic        misalign_err,
`endif
  output logic        fetch_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_FULL   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_fetch_busy;
  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_mem_pc  [DEPTH];
  logic [31:0]   r_mem_ins [DEPTH];
  logic [31:0]   r_head_pc;
  logic [31:0]   r_head_ins;

  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic          w_head_from_push;
  state_t        w_state_nxt;
  logic [31:0]   w_redirect_tgt;

  // The PC always sits on a word boundary, so the ROM index is simply pc[31:2].
  assign rom_addr       = r_pc;
  assign ins_valid      = (r_count != '0);
  assign ins_out        = r_head_ins;
  assign ins_pc         = r_head_pc;
  assign fetch_busy     = r_fetch_busy;
  assign w_redirect_tgt = redirect_pc & ~32'h3;

  // A redirect suppresses both FIFO ports for that cycle. A push is allowed
  // when the FIFO is full, provided a pop frees a slot in the same cycle.
  assign w_pop  = ins_valid & ins_ready & ~redirect;
  assign w_push = (r_state == S_FETCH) & ~redirect & ((r_count < FULL_CNT) | w_pop);

  // The new head comes straight from the ROM when the FIFO would otherwise
  // be empty after this cycle's pop.
  assign w_head_from_push = w_push & ((r_count == '0) | ((r_count == CW'(1)) & w_pop));

  // Occupancy and read pointer for the next cycle.
  always_comb begin
    w_count_nxt = r_count;
    w_rptr_nxt  = r_rptr;
    if (redirect) begin
      w_count_nxt = '0;
      w_rptr_nxt  = '0;
    end else begin
      if (w_pop) w_rptr_nxt = r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Next-state decision. Decisions that depend on fullness use the
  // post-edge occupancy.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = halt ? S_HALTED : S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = halt ? S_HALTED : S_FETCH;
        S_FETCH:  begin
          if (halt)                         w_state_nxt = S_HALTED;
          else if (w_count_nxt == FULL_CNT) w_state_nxt = S_FULL;
          else                              w_state_nxt = S_FETCH;
        end
        S_FULL:   begin
          if (halt)       w_state_nxt = S_HALTED;
          else if (w_pop) w_state_nxt = S_FETCH;
          else            w_state_nxt = S_FULL;
        end
        S_HALTED: begin
          if (halt)                        w_state_nxt = S_HALTED;
          else if (w_count_nxt < FULL_CNT) w_state_nxt = S_FETCH;
          else                             w_state_nxt = S_FULL;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Fetch FSM state plus its registered busy indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fetch_busy <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_busy <= (w_state_nxt == S_FETCH);
    end
  end

  // Program counter: advances on each push and is reloaded on a redirect.
  // Wraparound past the top of the address space is plain modulo arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC & ~32'h3;
    end else if (redirect) begin
      r_pc <= w_redirect_tgt;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy. A redirect or reset discards all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_rptr  <= w_rptr_nxt;
      if (redirect)    r_wptr <= '0;
      else if (w_push) r_wptr <= r_wptr + PW'(1);
    end
  end

  // FIFO storage. Pointers qualify the contents, so this needs no reset.
  // Undefined ROM data is stored as-is.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]  <= r_pc;
      r_mem_ins[r_wptr] <= rom_ins;
    end
  end

  // Registered head entry. It only moves on a pop or a fill-from-empty,
  // so it stays stable while decode stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_pc  <= '0;
      r_head_ins <= '0;
    end else if (!redirect && (w_count_nxt != '0)) begin
      if (w_head_from_push) begin
        r_head_pc  <= r_pc;
        r_head_ins <= rom_ins;
      end else begin
        r_head_pc  <= r_mem_pc[w_rptr_nxt];
        r_head_ins <= r_mem_ins[w_rptr_nxt];
      end
    end
  end

`ifdef IFETCH_ALIGN_CHK_EN
  logic r_misalign_err;
  assign misalign_err = r_misalign_err;

  // Sticky misalignment flag: set by an unaligned redirect and cleared by an aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign_err <= 1'b0;
    end else if (redirect) begin
      r_misalign_err <= |redirect_pc[1:0];
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios followed by a randomized run.
// All are checked against a queue-based reference model of the fetch/FIFO rules.
module tb_ifetch_ctrl;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  localparam int M_IDLE   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_FULL   = 2;
  localparam int M_HALTED = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_ins;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        fetch_busy;
`ifdef IFETCH_ALIGN_CHK_EN
  logic        misalign_err;
`endif

  int ncmp = 0;
  int nfail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  int          mst;
  logic [31:0] mpc;
  logic        merr;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign rom_ins = rom_fn(rom_addr);

  ifetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_addr     (rom_addr),
    .rom_ins      (rom_ins),
    .halt         (halt),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins_out      (ins_out),
    .ins_pc       (ins_pc),
`ifdef IFETCH_ALIGN_CHK_EN
    .misalign_err (misalign_err),
`endif
    .fetch_busy   (fetch_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: apply one clock edge with the given inputs.
  task automatic model_edge(input logic h, input logic rd, input logic [31:0] rp, input logic rdy);
    bit   pop;
    bit   push;
    ent_t e;
    if (rd) begin
      q.delete();
      mpc  = rp & ~32'h3;
      mst  = h ? M_HALTED : M_FETCH;
      merr = (rp[1:0] != 2'b00);
    end else begin
      pop  = (q.size() > 0) && rdy;
      push = (mst == M_FETCH) && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc  = mpc;
        e.ins = rom_fn(mpc);
        q.push_back(e);
        mpc = mpc + 32'd4;
      end
      case (mst)
        M_IDLE:   mst = h ? M_HALTED : M_FETCH;
        M_FETCH:  mst = h ? M_HALTED : ((q.size() == DEPTH) ? M_FULL : M_FETCH);
        M_FULL:   mst = h ? M_HALTED : (pop ? M_FETCH : M_FULL);
        default:  mst = h ? M_HALTED : ((q.size() < DEPTH) ? M_FETCH : M_FULL);
      endcase
    end
  endtask

  task automatic check_all();
    chk("valid", {31'd0, ins_valid}, {31'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      chk("head_pc", ins_pc, q[0].pc);
      chk("head_ins", ins_out, q[0].ins);
    end
    chk("rom_addr", rom_addr, mpc);
    chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, (mst == M_FETCH)});
`ifdef IFETCH_ALIGN_CHK_EN
    chk("misalign", {31'd0, misalign_err}, {31'd0, merr});
`endif
  endtask

  // Drive inputs, take one clock edge, update the model, then check just after the edge.
  task automatic step(input logic h, input logic rd, input logic [31:0] rp, input logic rdy);
    halt        = h;
    redirect    = rd;
    redirect_pc = rp;
    ins_ready   = rdy;
    @(posedge clk);
    model_edge(h, rd, rp, rdy);
    #1;
    check_all();
  endtask

  // Asynchronous reset applied between edges. Outputs are checked while reset is held.
  task automatic do_reset();
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ins_ready   = 1'b0;
    rst_n       = 1'b0;
    #2;
    q.delete();
    mst  = M_IDLE;
    mpc  = RESET_PC;
    merr = 1'b0;
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_ins_out", ins_out, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    chk("rst_rom_addr", rom_addr, RESET_PC);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
`ifdef IFETCH_ALIGN_CHK_EN
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    logic        h;
    logic        rd;
    logic        rdy;
    logic [31:0] rp;

    // 1: reset release with decode always ready
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_valid_after_1edge", {31'd0, ins_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_valid_after_2edges", {31'd0, ins_valid}, 32'd1);
    chk("t1_pc0", ins_pc, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t1_pc_seq", ins_pc, 32'(i * 4));
    end

    // 2: decode stalled until the FIFO fills, then drains without gaps
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_rom_addr_frozen", rom_addr, 32'h10);
    chk("t2_not_busy_full", {31'd0, fetch_busy}, 32'd0);
    chk("t2_head_held", ins_pc, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t2_drain_valid", {31'd0, ins_valid}, 32'd1);
      chk("t2_drain_pc", ins_pc, 32'(i * 4));
    end

    // 3: redirect while three entries are buffered
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    chk("t3_flushed", {31'd0, ins_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_target_pc", ins_pc, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_next_pc", ins_pc, 32'h44);

    // 4: halt with a full FIFO drains it and freezes the fetch address
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("t4_drained", {31'd0, ins_valid}, 32'd0);
    chk("t4_rom_frozen", rom_addr, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_resume_pc", ins_pc, 32'h10);

    // 5: PC wraps from the top of the address space to zero
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_pc_f8", ins_pc, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_pc_fc", ins_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_pc_wrap", ins_pc, 32'h0);

`ifdef IFETCH_ALIGN_CHK_EN
    // 6: sticky misalignment flag
    step(1'b0, 1'b1, 32'h22, 1'b1);
    chk("t6_err_set", {31'd0, misalign_err}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_truncated_pc", ins_pc, 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_err_sticky", {31'd0, misalign_err}, 32'd1);
    step(1'b0, 1'b1, 32'h30, 1'b1);
    chk("t6_err_clear", {31'd0, misalign_err}, 32'd0);
`endif

    // 7: randomized traffic against the model, with a reset in the middle
    do_reset();
    h = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) < 8) h = ~h;
      rd  = ($urandom_range(99, 0) < 7);
      rdy = ($urandom_range(99, 0) < 60);
      rp  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(h, rd, rp, rdy);
      if (i == 300) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
